counter_ctrl: RTL
=================

Name: counter_ctrl

Overview:
Run-control sequencer for the board counter datapath (clock_divider -> counter -> display). It debounces three raw pushbuttons (start/stop, lap, clear) and runs a stopwatch FSM. The FSM drives the counter's enable and a synchronous clear, and selects the value sent to the 7-segment display: either the live count or a frozen lap snapshot. It sits in the top level between the board buttons, the counter and the display.

Parameters:
N, 16, width of count_in and disp_value.
DB_CYCLES, 500000, consecutive clk cycles a synchronized button level must differ from its stable value before it is accepted (5 ms at 100 MHz). Benches override this to 4.
SATURATE, 1, 1 = automatic pause when count reaches all-ones; 0 = the counter is allowed to wrap.

Ports:
clk  input  1  system clock (100 MHz).
reset  input  1  asynchronous, active-low reset.
btn_start  input  1  raw start/stop pushbutton, asynchronous, active-high.
btn_lap  input  1  raw lap pushbutton, asynchronous, active-high.
btn_clear  input  1  raw clear pushbutton, asynchronous, active-high.
count_in  input  N  current counter value, synchronous to clk.
cnt_enable  output  1  counter enable (level).
cnt_clear  output  1  one-cycle synchronous clear request to the counter.
disp_value  output  N  value for the display (live count or lap snapshot).
state  output  2  FSM state for LEDs: IDLE=0, RUN=1, LAP=2, PAUSE=3.

Behaviour:
- reset low, asynchronous: state=IDLE, cnt_enable=0, cnt_clear=0, lap_reg=0, disp_value=count_in. Synchronizers, debounce counters and stable levels are cleared to 0.
- Per button: 2-flop synchronizer -> debounce counter -> stable level.
  - When sync != stable, the counter increments. When sync == stable, the counter resets to 0.
  - When the counter reaches DB_CYCLES-1 while sync != stable, stable takes the sync value and the counter resets.
  - A press event is a one-cycle pulse on a 0->1 transition of stable. A release generates no event.
  - Latency from a clean raw edge to the press pulse is DB_CYCLES+2 cycles. Any glitch shorter than DB_CYCLES cycles produces no event.
- Event priority within one cycle: clear > start > lap. Only the highest-priority event that is legal in the current state is acted on; all others are dropped.
- FSM transitions (registered):
  - IDLE: start -> RUN. lap and clear are ignored.
  - RUN: start -> PAUSE. lap -> LAP and lap_reg <= count_in in the same edge. clear is ignored.
  - LAP: lap -> RUN (display released). start -> PAUSE. clear is ignored. lap_reg holds its value.
  - PAUSE: start -> RUN. clear -> IDLE with cnt_clear=1 for exactly one cycle, registered on that edge. lap is ignored.
- Saturation (SATURATE=1): in RUN or LAP, if count_in == 2^N-1, the FSM goes to PAUSE on the next edge. This has priority over button events in that cycle. From PAUSE at max, start -> RUN and then RUN -> PAUSE again on the following edge. With SATURATE=0 there is no check and the counter wraps.
- Output decode (Moore, combinational from the state register):
  - cnt_enable = 1 in RUN and LAP, 0 in IDLE and PAUSE.
  - disp_value = lap_reg in LAP, count_in otherwise.
  - state is the encoding listed under Ports.
- Reset mid-operation: return immediately to the reset values. A partially debounced press is discarded, and no cnt_clear pulse is issued.
- A held button produces exactly one event. A second event requires a release that is stable for DB_CYCLES cycles, followed by a new press.

Test Plan:
1. DB_CYCLES=4, N=4. Reset, then hold btn_start high for 10 cycles -> one press pulse 6 cycles after the edge; state 0->1; cnt_enable=1.
2. In RUN, pulse btn_start high for 2 cycles (glitch) -> no event, state stays 1. Then hold it for 8 cycles -> state=3, cnt_enable=0.
3. RUN with count_in=5, press lap -> state=2, disp_value=5 while count_in advances to 9. Press lap again -> state=1, disp_value=9.
4. PAUSE, press clear -> cnt_clear high for exactly 1 cycle, state=0. Press clear in RUN -> ignored, cnt_clear stays 0.
5. Stable start and clear events on the same cycle in PAUSE -> clear wins: state=0, one cnt_clear pulse. The same pair in RUN -> start acts: state=3.
6. SATURATE=1, RUN, drive count_in=15 -> state=3 next edge. SATURATE=0 -> state stays 1. Assert reset low mid-debounce -> all outputs at reset values asynchronously, no later event.

Source files
------------

// File: rtl/counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_ctrl_if
// Bus between the run-control sequencer and the counter/display datapath.
//   count_in   : current counter value (counter -> controller)
//   cnt_enable : counter enable level (controller -> counter)
//   cnt_clear  : one-cycle synchronous clear request (controller -> counter)
//   disp_value : value for the 7-segment display (controller -> display)
//   state      : FSM state for the LEDs, IDLE=0 RUN=1 LAP=2 PAUSE=3
// The controller takes the master modport; the counter/display side the slave.
// -----------------------------------------------------------------------------
interface counter_ctrl_if #(
  parameter int N = 16
) ();
  logic [N-1:0] count_in;
  logic         cnt_enable;
  logic         cnt_clear;
  logic [N-1:0] disp_value;
  logic [1:0]   state;

  modport master (
    input  count_in,
    output cnt_enable,
    output cnt_clear,
    output disp_value,
    output state
  );

  modport slave (
    output count_in,
    input  cnt_enable,
    input  cnt_clear,
    input  disp_value,
    input  state
  );
endinterface

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Stopwatch run-control sequencer. Debounces three raw pushbuttons and runs an
// IDLE/RUN/LAP/PAUSE state machine that enables and clears the counter and
// picks the displayed value (live count or frozen lap snapshot).
// Ports:
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   btn_start : raw start/stop button, asynchronous, active-high
//   btn_lap   : raw lap button, asynchronous, active-high
//   btn_clear : raw clear button, asynchronous, active-high
//   bus       : counter/display bus (count_in, cnt_enable, cnt_clear,
//               disp_value, state)
// Parameters:
//   N         : counter / display width
//   DB_CYCLES : cycles a synchronized level must persist before acceptance
//   SATURATE  : 1 = auto-pause when count_in is all-ones, 0 = let it wrap
// -----------------------------------------------------------------------------
module counter_ctrl #(
  parameter int N         = 16,
  parameter int DB_CYCLES = 500000,
  parameter int SATURATE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_start,
  input  logic            btn_lap,
  input  logic            btn_clear,
  counter_ctrl_if.master  bus
);

  // Counter only has to reach DB_CYCLES-1.
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  // Button bit order everywhere: [0]=start, [1]=lap, [2]=clear.
  logic [2:0]    raw;
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    stable;
  logic [2:0]    stable_q;
  logic [CW-1:0] db_cnt [3];
  logic [2:0]    press;

  logic          start_ev;
  logic          lap_ev;
  logic          clear_ev;
  logic          at_max;

  state_t        state_q;
  logic          cnt_clear_q;
  logic [N-1:0]  lap_reg;

  assign raw = {btn_clear, btn_lap, btn_start};

  // ---------------------------------------------------------------------------
  // Synchronizer + debounce. The counter measures how long the synchronized
  // level has disagreed with the accepted level; any agreement restarts it, so
  // a glitch shorter than DB_CYCLES never gets through.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a   <= '0;
      sync_b   <= '0;
      stable   <= '0;
      stable_q <= '0;
      // NOTE: db_cnt is a handful of flops, not a RAM, so it is reset with the
      // rest; otherwise a half-debounced press could survive a reset.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync_b take the old sync_a, which is
      // what makes this a two-stage synchronizer rather than a single wire.
      sync_a   <= raw;
      sync_b   <= sync_a;
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Press = rising edge of the accepted level; releases are silent.
  assign press    = stable & ~stable_q;
  assign start_ev = press[0];
  assign lap_ev   = press[1];
  assign clear_ev = press[2];

  assign at_max = (SATURATE != 0) && (bus.count_in == {N{1'b1}});

  // ---------------------------------------------------------------------------
  // Run-control FSM. Each state checks only the events it accepts, in
  // clear > start > lap order, so an illegal higher-priority event never masks
  // a legal lower-priority one. Saturation outranks every button.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_clear_q <= 1'b0;
      lap_reg     <= '0;
    end else begin
      cnt_clear_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ev) state_q <= RUN;
        end
        RUN: begin
          if (at_max) begin
            state_q <= PAUSE;
          end else if (start_ev) begin
            state_q <= PAUSE;
          end else if (lap_ev) begin
            state_q <= LAP;
            lap_reg <= bus.count_in;
          end
        end
        LAP: begin
          if (at_max || start_ev) begin
            state_q <= PAUSE;
          end else if (lap_ev) begin
            state_q <= RUN;
          end
        end
        PAUSE: begin
          if (clear_ev) begin
            state_q     <= IDLE;
            cnt_clear_q <= 1'b1;
          end else if (start_ev) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore decode from the state register.
  assign bus.state      = state_q;
  assign bus.cnt_enable = (state_q == RUN) || (state_q == LAP);
  assign bus.cnt_clear  = cnt_clear_q;
  assign bus.disp_value = (state_q == LAP) ? lap_reg : bus.count_in;

endmodule
